pea_firing_scheduler: RTL and testbench
=======================================

# pea_firing_scheduler

Top-level CFDF firing scheduler for the polynomial evaluation accelerator. It evaluates the enable conditions from input/output FIFO populations and decides when to fire the nested firing-state FSM. Each instruction is fired in two phases: a SETUP_INSTR firing fetches and decodes the command, then an INSTR firing executes it. The block issues the start pulse and mode, waits for the one-cycle done, guards each firing with a watchdog, and counts completed instructions.

## Interface
- word_size, 16, width of FIFO population/free-space words
- timeout_cycles, 4096, max cycles in a WAIT state before a watchdog error
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- run  in  1  software enable; low = finish current firing, then stay in IDLE
- clear_err  in  1  one-cycle pulse, leaves ERROR state
- pop_in_fifo_command  in  word_size  tokens in input command FIFO
- pop_in_fifo_data  in  word_size  tokens in input data FIFO
- free_out_result  in  word_size  free slots in output result FIFO
- free_out_status  in  word_size  free slots in output status FIFO
- instr  in  8  decoded opcode from firing FSM (valid after SETUP done)
- arg2  in  5  decoded N / b argument from firing FSM
- done_fsm2  in  1  one-cycle completion pulse from firing FSM
- start_fsm2  out  1  one-cycle firing request to firing FSM
- next_instr  out  2  firing mode: 2'b00 SETUP_INSTR, 2'b01 INSTR
- busy  out  1  high in every state except IDLE and ERROR
- bad_instr  out  1  one-cycle pulse on an unsupported opcode/argument
- error  out  1  high while in ERROR (watchdog expired)
- fire_count  out  16  completed INSTR firings, wraps 16'hFFFF->0

## Operation
- States: IDLE, SETUP_START, SETUP_WAIT, CHECK, INSTR_START, INSTR_WAIT, ERROR.
- IDLE -> SETUP_START when run=1 and pop_in_fifo_command>=1.
- SETUP_START: start_fsm2=1, next_instr=00. Always moves to SETUP_WAIT.
- SETUP_WAIT: on done_fsm2, go to CHECK. On watchdog expiry, go to ERROR.
- CHECK: evaluates token requirements from instr/arg2.
  - STP (0): data>=arg2+1, result>=1, status>=1.
  - EVP (1): data>=1, result>=1, status>=1.
  - EVB (2): arg2>=1, data>=arg2, result>=arg2, status>=1.
  - RST (3): no token requirements.
- CHECK outcomes:
  - Requirement met: go to INSTR_START.
  - Requirement not met: stay in CHECK, holding the decoded command.
  - Opcode >3, or EVB with arg2=0: pulse bad_instr for 1 cycle, then go to IDLE. No INSTR firing occurs.
- INSTR_START: start_fsm2=1, next_instr=01. Then go to INSTR_WAIT.
- INSTR_WAIT: on done_fsm2, fire_count+1, then go to IDLE. On watchdog expiry, go to ERROR.
- ERROR: holds until clear_err=1, then goes to IDLE. Counters are unchanged. start_fsm2 is never asserted in ERROR.
- run is sampled only in IDLE. Deasserting run does not abort SETUP/CHECK/INSTR.
- Comparisons are unsigned at word_size bits. arg2+1 is computed at word_size bits, so there is no overflow.

## Timing
- All outputs are Moore outputs decoded from the registered state. fire_count and bad_instr are registers.
- Reset values: start_fsm2=0, next_instr=00, busy=0, bad_instr=0, error=0, fire_count=0, state=IDLE.
- next_instr is held stable from each *_START through the end of the matching *_WAIT. In IDLE, CHECK and ERROR it holds its last value; after reset it is 00.
- Latency: enable true in IDLE at edge k gives start_fsm2 high during cycle k+1. CHECK satisfied at edge k gives INSTR_START during cycle k+1.
- done_fsm2 is ignored outside the WAIT states, including the START cycle.
- Watchdog counter:
  - Cleared on entering each WAIT state.
  - Expires when the count reaches timeout_cycles.
  - If done_fsm2 and expiry occur in the same cycle, done wins.
- Async reset mid-firing returns to IDLE immediately. The firing FSM shares rst, so no handshake is pending afterwards.
- Minimum instruction turnaround: 5 cycles (SETUP_START, SETUP_WAIT>=1, CHECK, INSTR_START, INSTR_WAIT>=1).

## Test plan
- EVP happy path: cmd=1, data=1, result/status free=4, instr=1, done after 3 cycles in each WAIT -> two start pulses (next_instr 00 then 01), fire_count=1, back in IDLE.
- STP gating: instr=0, arg2=3, data=3 -> stays in CHECK with no start pulse. Raise data to 4 -> INSTR_START on the next cycle.
- EVB with b=0, then opcode 8'd7 -> bad_instr pulses once each, no INSTR start, fire_count unchanged.
- Watchdog: timeout_cycles=16, withhold done in INSTR_WAIT -> error=1 after 16 cycles. Pulse clear_err -> IDLE with error=0. Done and expiry in the same cycle -> no error.
- run=0 during INSTR_WAIT -> firing completes and fire_count increments, then the block stays in IDLE with cmd=5 until run=1.
- Async reset asserted during SETUP_WAIT -> all outputs return to reset values within the reset assertion. fire_count wrap: preload via 65536 RST firings -> 0.

Source files
------------

// File: rtl/pea_firing_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pea_firing_scheduler
// Brief    : CFDF firing scheduler for the polynomial evaluation accelerator.
//            Fires the nested firing FSM in two phases (SETUP_INSTR, then
//            INSTR), gates each INSTR firing on FIFO populations, guards every
//            firing with a watchdog and counts completed instructions.
// Revision : 1.0 - initial release
// ============================================================================
module pea_firing_scheduler #(
  parameter int WORD_SIZE      = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 clear_err,
  input  logic [WORD_SIZE-1:0] pop_in_fifo_command,
  input  logic [WORD_SIZE-1:0] pop_in_fifo_data,
  input  logic [WORD_SIZE-1:0] free_out_result,
  input  logic [WORD_SIZE-1:0] free_out_status,
  input  logic [7:0]           instr,
  input  logic [4:0]           arg2,
  input  logic                 done_fsm2,
  output logic                 start_fsm2,
  output logic [1:0]           next_instr,
  output logic                 busy,
  output logic                 bad_instr,
  output logic                 error,
  output logic [15:0]          fire_count
);

  // Scheduler states
  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_SETUP_START = 3'd1;
  localparam logic [2:0] S_SETUP_WAIT  = 3'd2;
  localparam logic [2:0] S_CHECK       = 3'd3;
  localparam logic [2:0] S_INSTR_START = 3'd4;
  localparam logic [2:0] S_INSTR_WAIT  = 3'd5;
  localparam logic [2:0] S_ERROR       = 3'd6;

  // Firing modes presented to the firing FSM
  localparam logic [1:0] MODE_SETUP = 2'b00;
  localparam logic [1:0] MODE_INSTR = 2'b01;

  // Opcodes
  localparam logic [7:0] OP_STP = 8'd0;
  localparam logic [7:0] OP_EVP = 8'd1;
  localparam logic [7:0] OP_EVB = 8'd2;
  localparam logic [7:0] OP_RST = 8'd3;

  // Watchdog counts WAIT cycles; the last legal count is TIMEOUT_CYCLES-1,
  // so a WAIT state that has lasted TIMEOUT_CYCLES cycles without done exits.
  localparam int             WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]           state;
  logic [2:0]           state_nxt;
  logic [WD_W-1:0]      wd_count;
  logic                 wd_expired;
  logic                 in_wait;
  logic [WORD_SIZE-1:0] arg2_w;
  logic [WORD_SIZE-1:0] arg2_p1;
  logic                 one_each;
  logic                 req_met;
  logic                 cmd_bad;

  assign in_wait    = (state == S_SETUP_WAIT) || (state == S_INSTR_WAIT);
  assign wd_expired = (wd_count == WD_LAST);

  // arg2 widened to the FIFO word width so arg2+1 cannot overflow
  assign arg2_w   = WORD_SIZE'(arg2);
  assign arg2_p1  = arg2_w + WORD_SIZE'(1);
  assign one_each = (free_out_result != '0) && (free_out_status != '0);

  // Token requirement and legality of the decoded command
  always_comb begin
    req_met = 1'b0;
    cmd_bad = 1'b0;
    case (instr)
      OP_STP:  req_met = (pop_in_fifo_data >= arg2_p1) && one_each;
      OP_EVP:  req_met = (pop_in_fifo_data != '0) && one_each;
      OP_EVB: begin
        cmd_bad = (arg2 == 5'd0);
        req_met = (arg2 != 5'd0) && (pop_in_fifo_data >= arg2_w) &&
                  (free_out_result >= arg2_w) && (free_out_status != '0);
      end
      OP_RST:  req_met = 1'b1;
      default: cmd_bad = 1'b1;
    endcase
  end

  // Next-state selection; done beats watchdog expiry in the WAIT states
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (run && (pop_in_fifo_command != '0)) state_nxt = S_SETUP_START;
      end
      S_SETUP_START: state_nxt = S_SETUP_WAIT;
      S_SETUP_WAIT: begin
        if (done_fsm2)       state_nxt = S_CHECK;
        else if (wd_expired) state_nxt = S_ERROR;
      end
      S_CHECK: begin
        if (cmd_bad)      state_nxt = S_IDLE;
        else if (req_met) state_nxt = S_INSTR_START;
      end
      S_INSTR_START: state_nxt = S_INSTR_WAIT;
      S_INSTR_WAIT: begin
        if (done_fsm2)       state_nxt = S_IDLE;
        else if (wd_expired) state_nxt = S_ERROR;
      end
      S_ERROR: begin
        if (clear_err) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Watchdog: zero outside WAIT, so it is cleared on every WAIT entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         wd_count <= '0;
    else if (in_wait) wd_count <= wd_count + WD_W'(1);
    else              wd_count <= '0;
  end

  // Firing mode: loaded when a START state is entered, held otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               next_instr <= MODE_SETUP;
    else if (state_nxt == S_SETUP_START)    next_instr <= MODE_SETUP;
    else if (state_nxt == S_INSTR_START)    next_instr <= MODE_INSTR;
  end

  // Completed INSTR firings, naturally wrapping at 16 bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  fire_count <= 16'd0;
    else if ((state == S_INSTR_WAIT) && done_fsm2) fire_count <= fire_count + 16'd1;
  end

  // One-cycle flag for a rejected command, visible in the following IDLE cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bad_instr <= 1'b0;
    else      bad_instr <= (state == S_CHECK) && cmd_bad;
  end

  assign start_fsm2 = (state == S_SETUP_START) || (state == S_INSTR_START);
  assign busy       = (state != S_IDLE) && (state != S_ERROR);
  assign error      = (state == S_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_pea_firing_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_pea_firing_scheduler
// Brief    : Directed self-checking bench for pea_firing_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pea_firing_scheduler;

  logic        clk;
  logic        rst;
  logic        run;
  logic        clear_err;
  logic [15:0] pop_in_fifo_command;
  logic [15:0] pop_in_fifo_data;
  logic [15:0] free_out_result;
  logic [15:0] free_out_status;
  logic [7:0]  instr;
  logic [4:0]  arg2;
  logic        done_fsm2;
  logic        start_fsm2;
  logic [1:0]  next_instr;
  logic        busy;
  logic        bad_instr;
  logic        error;
  logic [15:0] fire_count;

  int total = 0;
  int bad   = 0;

  pea_firing_scheduler #(
    .WORD_SIZE      (16),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .run                 (run),
    .clear_err           (clear_err),
    .pop_in_fifo_command (pop_in_fifo_command),
    .pop_in_fifo_data    (pop_in_fifo_data),
    .free_out_result     (free_out_result),
    .free_out_status     (free_out_status),
    .instr               (instr),
    .arg2                (arg2),
    .done_fsm2           (done_fsm2),
    .start_fsm2          (start_fsm2),
    .next_instr          (next_instr),
    .busy                (busy),
    .bad_instr           (bad_instr),
    .error               (error),
    .fire_count          (fire_count)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are examined 1 ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // From IDLE with a command queued: SETUP_START, one SETUP_WAIT cycle, then
  // done so the block lands in CHECK. Command FIFO is emptied on the way.
  task automatic to_check();
    step();                       // SETUP_START
    chk("setup_start", 32'(start_fsm2), 32'd1);
    chk("setup_mode", 32'(next_instr), 32'd0);
    step();                       // SETUP_WAIT
    done_fsm2 = 1'b1;
    pop_in_fifo_command = 16'd0;
    step();                       // CHECK
    done_fsm2 = 1'b0;
  endtask

  initial begin
    rst = 1'b0; run = 1'b0; clear_err = 1'b0; done_fsm2 = 1'b0;
    pop_in_fifo_command = '0; pop_in_fifo_data = '0;
    free_out_result = '0; free_out_status = '0; instr = '0; arg2 = '0;
    steps(2);

    // ---- reset state ----
    chk("rst_start", 32'(start_fsm2), 32'd0);
    chk("rst_mode", 32'(next_instr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bad", 32'(bad_instr), 32'd0);
    chk("rst_err", 32'(error), 32'd0);
    chk("rst_cnt", 32'(fire_count), 32'd0);
    rst = 1'b1;

    // ---- EVP happy path, done after 3 cycles in each WAIT ----
    pop_in_fifo_command = 16'd1; pop_in_fifo_data = 16'd1;
    free_out_result = 16'd4; free_out_status = 16'd4;
    instr = 8'd1; arg2 = 5'd0; run = 1'b1;
    step();
    chk("evp_sstart", 32'(start_fsm2), 32'd1);
    chk("evp_smode", 32'(next_instr), 32'd0);
    chk("evp_busy", 32'(busy), 32'd1);
    step();
    chk("evp_swait", 32'(start_fsm2), 32'd0);
    steps(2);
    done_fsm2 = 1'b1; pop_in_fifo_command = 16'd0;
    step();                       // CHECK
    done_fsm2 = 1'b0;
    chk("evp_check", 32'(start_fsm2), 32'd0);
    step();
    chk("evp_istart", 32'(start_fsm2), 32'd1);
    chk("evp_imode", 32'(next_instr), 32'd1);
    step();
    chk("evp_iwait", 32'(start_fsm2), 32'd0);
    chk("evp_iwmode", 32'(next_instr), 32'd1);
    steps(2);
    done_fsm2 = 1'b1;
    step();                       // IDLE
    done_fsm2 = 1'b0;
    chk("evp_cnt", 32'(fire_count), 32'd1);
    chk("evp_idle", 32'(busy), 32'd0);
    chk("evp_hold", 32'(next_instr), 32'd1);

    // ---- STP gating: arg2=3 needs data>=4 ----
    pop_in_fifo_command = 16'd1; instr = 8'd0; arg2 = 5'd3; pop_in_fifo_data = 16'd3;
    to_check();
    for (int i = 0; i < 3; i++) begin
      chk("stp_hold_start", 32'(start_fsm2), 32'd0);
      chk("stp_hold_busy", 32'(busy), 32'd1);
      step();
    end
    pop_in_fifo_data = 16'd4;
    step();
    chk("stp_istart", 32'(start_fsm2), 32'd1);
    chk("stp_imode", 32'(next_instr), 32'd1);
    step();
    done_fsm2 = 1'b1;
    step();
    done_fsm2 = 1'b0;
    chk("stp_cnt", 32'(fire_count), 32'd2);

    // ---- EVB with b=0 rejected ----
    pop_in_fifo_command = 16'd1; instr = 8'd2; arg2 = 5'd0;
    to_check();
    chk("evb0_nobad", 32'(bad_instr), 32'd0);
    step();
    chk("evb0_bad", 32'(bad_instr), 32'd1);
    chk("evb0_idle", 32'(busy), 32'd0);
    chk("evb0_nostart", 32'(start_fsm2), 32'd0);
    step();
    chk("evb0_pulse", 32'(bad_instr), 32'd0);

    // ---- opcode 7 rejected ----
    pop_in_fifo_command = 16'd1; instr = 8'd7; arg2 = 5'd1;
    to_check();
    step();
    chk("op7_bad", 32'(bad_instr), 32'd1);
    chk("op7_nostart", 32'(start_fsm2), 32'd0);
    step();
    chk("op7_pulse", 32'(bad_instr), 32'd0);
    chk("op7_cnt", 32'(fire_count), 32'd2);

    // ---- watchdog expiry in INSTR_WAIT ----
    pop_in_fifo_command = 16'd1; instr = 8'd3;
    to_check();
    step();                       // INSTR_START
    chk("wd_istart", 32'(start_fsm2), 32'd1);
    step();                       // INSTR_WAIT cycle 1
    steps(15);                    // cycle 16
    chk("wd_pre_err", 32'(error), 32'd0);
    chk("wd_pre_busy", 32'(busy), 32'd1);
    pop_in_fifo_command = 16'd1;
    step();
    chk("wd_err", 32'(error), 32'd1);
    chk("wd_err_busy", 32'(busy), 32'd0);
    steps(3);
    chk("wd_err_hold", 32'(error), 32'd1);
    chk("wd_err_nostart", 32'(start_fsm2), 32'd0);
    clear_err = 1'b1; pop_in_fifo_command = 16'd0;
    step();
    clear_err = 1'b0;
    chk("wd_clear", 32'(error), 32'd0);
    chk("wd_cnt", 32'(fire_count), 32'd2);

    // ---- done and expiry in the same cycle: done wins ----
    pop_in_fifo_command = 16'd1;
    to_check();
    step();                       // INSTR_START
    step();                       // INSTR_WAIT cycle 1
    steps(15);                    // cycle 16, expiry cycle
    done_fsm2 = 1'b1;
    step();
    done_fsm2 = 1'b0;
    chk("tie_noerr", 32'(error), 32'd0);
    chk("tie_cnt", 32'(fire_count), 32'd3);

    // ---- run=0 during INSTR_WAIT, EVB b=2 satisfied ----
    pop_in_fifo_command = 16'd5; instr = 8'd2; arg2 = 5'd2;
    pop_in_fifo_data = 16'd2; free_out_result = 16'd2; free_out_status = 16'd1;
    to_check();
    step();
    chk("evb_istart", 32'(start_fsm2), 32'd1);
    step();                       // INSTR_WAIT
    run = 1'b0; pop_in_fifo_command = 16'd5;
    step();
    done_fsm2 = 1'b1;
    step();
    done_fsm2 = 1'b0;
    chk("run0_cnt", 32'(fire_count), 32'd4);
    steps(3);
    chk("run0_idle", 32'(busy), 32'd0);
    chk("run0_nostart", 32'(start_fsm2), 32'd0);
    run = 1'b1;
    step();
    chk("run1_start", 32'(start_fsm2), 32'd1);
    chk("run1_mode", 32'(next_instr), 32'd0);

    // ---- asynchronous reset during SETUP_WAIT ----
    step();                       // SETUP_WAIT
    chk("ar_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("ar_busy0", 32'(busy), 32'd0);
    chk("ar_start0", 32'(start_fsm2), 32'd0);
    chk("ar_mode0", 32'(next_instr), 32'd0);
    chk("ar_cnt0", 32'(fire_count), 32'd0);
    chk("ar_err0", 32'(error), 32'd0);
    run = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("ar_stay_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
